conv_rr_scheduler: RTL and testbench
====================================

// Module: conv_rr_scheduler
// PURPOSE
//  Round-robin scheduler that shares one pipelined 2x4x4 convolution datapath among NUM_REQ tile requesters.
//  Accepts at most one 128-bit IFM tile per cycle, drives the datapath's in_valid/IFM bus and tracks each
//  in-flight tile's requester ID through a LATENCY-deep tag pipe. Routes every 13-bit OFM result back to its owner.
//  Sits between the tile fetch units and the convolution datapath.
// PARAMETERS
//  NUM_REQ  2    number of requesters (2..8)
//  LATENCY  4    cycles from datapath in_valid high to its out_valid high
//  IDW      1    requester ID width, >= clog2(NUM_REQ)
// PORTS
//  clk            in   1            clock, all logic on posedge
//  rst_n          in   1            synchronous active-low reset
//  enable         in   1            1 = grants allowed; 0 = no new grants, in-flight tiles drain
//  req_valid      in   NUM_REQ      per-requester tile offered
//  req_ifm        in   NUM_REQ*128  per-requester tile; slice i = [128*i+127:128*i]; nibble n = IFM element n+1
//  req_ready      out  NUM_REQ      combinational grant; tile i accepted when req_valid[i] & req_ready[i]
//  conv_in_valid  out  1            to datapath in_valid, registered
//  conv_ifm       out  128          to datapath In_IFM_1..32 (nibble n -> In_IFM_{n+1}), registered
//  conv_out_valid in   1            from datapath out_valid
//  conv_ofm       in   13           from datapath Out_OFM
//  rsp_valid      out  NUM_REQ      one-hot result strobe to owning requester, registered
//  rsp_ofm        out  13           result value, registered, shared by all requesters
//  busy           out  1            1 while any tile is in flight, or conv_in_valid/rsp_valid is high
//  tag_err        out  1            sticky: datapath result without a tag, or tag with no result
//  done_cnt       out  16           total results delivered, wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): conv_in_valid=0, conv_ifm=0, rsp_valid=0, rsp_ofm=0, tag_err=0, done_cnt=0.
//   rr_ptr=0, all tag pipe valids cleared. Reset mid-operation discards in-flight tags.
//   Datapath results arriving after reset are ignored, and flag tag_err only if they arrive after rst_n returns high.
//  Arbitration (combinational):
//   - If enable=0, req_ready=0.
//   - Else grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - req_ready is one-hot or zero, and does not depend on conv_out_valid (the datapath never stalls).
//  Accept (posedge with handshake on g):
//   - conv_in_valid<=1, conv_ifm<=req_ifm slice g, rr_ptr<=(g+1) mod NUM_REQ.
//   - Tag stage0 <= {1,g}.
//   - No accept: conv_in_valid<=0, conv_ifm holds, stage0 valid<=0, rr_ptr holds.
//  Back-to-back accepts every cycle are legal; the datapath is fully pipelined.
//  Tag pipe: stages 0..LATENCY-1 shift every cycle unconditionally; stage LATENCY-1 aligns with conv_out_valid.
//  Result (posedge):
//   - rsp_valid <= conv_out_valid & tagv_last ? onehot(tag_last) : 0; rsp_ofm <= conv_ofm when conv_out_valid, else holds.
//   - done_cnt increments on each delivered result.
//   - conv_out_valid != tagv_last -> tag_err<=1 and no rsp_valid; cleared only by reset.
//  Latency: accept at edge k -> conv_in_valid high cycle k..k+1 -> rsp_valid high after edge k+LATENCY+1.
//  Throughput: 1 tile/cycle total; with all NUM_REQ requesting, each is granted once per NUM_REQ cycles.
//  enable falling: no new accepts; tiles already accepted still complete and produce rsp_valid.
//  busy = conv_in_valid | any tag valid | (|rsp_valid).
//  Simultaneous accept and result in the same cycle are independent; both take effect.
//  rr_ptr moves only on an accept, never on an idle cycle.
// TESTING (bench: datapath stub = LATENCY-cycle delay, OFM = sum of IFM nibbles)
//  1. Reset, req_valid=01, tile all nibbles=1 -> req_ready=01 same cycle;
//     rsp_valid=01, rsp_ofm=32 exactly 5 cycles after accept; done_cnt=1.
//  2. req_valid=11 held 6 cycles, tiles r0=all 2 / r1=all 3 -> grants alternate r0,r1,r0,r1,r0,r1;
//     rsp alternates 01/10 with ofm 64/96 on consecutive cycles; no bubbles.
//  3. req_valid=11, enable dropped after 2 accepts -> req_ready=00; exactly 2 rsp follow; busy falls 1 cycle after last rsp.
//  4. Stub injects conv_out_valid with no tile in flight -> tag_err=1 sticky, rsp_valid stays 0, done_cnt unchanged.
//  5. rst_n low for 1 cycle with 3 tiles in flight -> no rsp_valid for those tiles;
//     done_cnt=0; tag_err=1 only for stub results arriving after reset release.
//  6. Preload done_cnt=0xFFFF via 65535 tiles, one more tile -> done_cnt=0x0000.

Source files
------------

// File: rtl/conv_rr_scheduler.sv
// Round-robin front end for a shared, fully pipelined 2x4x4 convolution datapath.
// Grants one requester tile per cycle, tags it through the datapath latency and routes each OFM back to its owner.
module conv_rr_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int LATENCY = 4,
    parameter int IDW     = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*128-1:0] req_ifm,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   conv_in_valid,
    output logic [127:0]           conv_ifm,
    input  logic                   conv_out_valid,
    input  logic [12:0]            conv_ofm,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [12:0]            rsp_ofm,
    output logic                   busy,
    output logic                   tag_err,
    output logic [15:0]            done_cnt
);

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (id == IDW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     next_ptr;
    logic               accept;
    logic [127:0]       ifm_sel;
    logic [IDW-1:0]     conv_id_p0;
    logic [LATENCY-1:0] tag_vld_p;
    logic [IDW-1:0]     tag_id_p [LATENCY];
    logic               tag_hit;

    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        accept    = 1'b0;
        grant_idx = '0;
        idx       = 0;
        cand      = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = idx[IDW-1:0];
            if (!accept && enable && (|(req_valid & onehot(cand)))) begin
                accept    = 1'b1;
                grant_idx = cand;
            end
        end
        req_ready = accept ? onehot(grant_idx) : '0;
        next_ptr  = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        ifm_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) ifm_sel = req_ifm[i*128 +: 128];
        end
    end

    // Stage p0: granted tile registered onto the datapath input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conv_in_valid <= 1'b0;
            conv_ifm      <= '0;
            rr_ptr        <= '0;
        end else begin
            conv_in_valid <= accept;
            if (accept) begin
                conv_ifm <= ifm_sel;
                rr_ptr   <= next_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) conv_id_p0 <= grant_idx;
    end

    // Tag pipe: stage i tracks the datapath's (i+1)-th internal stage; the last one lines up with out_valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= conv_in_valid;
            for (int i = 1; i < LATENCY; i++) tag_vld_p[i] <= tag_vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id_p[0] <= conv_id_p0;
        for (int i = 1; i < LATENCY; i++) tag_id_p[i] <= tag_id_p[i-1];
    end

    assign tag_hit = conv_out_valid & tag_vld_p[LATENCY-1];

    // Result stage: route OFM to its owner, flag any result/tag disagreement
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_ofm   <= '0;
            tag_err   <= 1'b0;
            done_cnt  <= '0;
        end else begin
            rsp_valid <= tag_hit ? onehot(tag_id_p[LATENCY-1]) : '0;
            if (conv_out_valid) rsp_ofm <= conv_ofm;
            if (conv_out_valid != tag_vld_p[LATENCY-1]) tag_err <= 1'b1;
            if (tag_hit) done_cnt <= done_cnt + 16'd1;
        end
    end

    assign busy = conv_in_valid | (|tag_vld_p) | (|rsp_valid);

endmodule

// File: tb/tb_conv_rr_scheduler.sv
// Directed bench for conv_rr_scheduler with a LATENCY-cycle datapath stub whose OFM is the IFM nibble sum.
module tb_conv_rr_scheduler;
    localparam int NUM_REQ = 2;
    localparam int LAT     = 4;
    localparam int IDW     = 1;

    logic                   clk;
    logic                   rst_n;
    logic                   enable;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*128-1:0] req_ifm;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   conv_in_valid;
    logic [127:0]           conv_ifm;
    logic                   conv_out_valid;
    logic [12:0]            conv_ofm;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [12:0]            rsp_ofm;
    logic                   busy;
    logic                   tag_err;
    logic [15:0]            done_cnt;
    logic                   inj;

    int n_checks = 0;
    int n_pass   = 0;

    conv_rr_scheduler #(.NUM_REQ(NUM_REQ), .LATENCY(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_ifm(req_ifm), .req_ready(req_ready),
        .conv_in_valid(conv_in_valid), .conv_ifm(conv_ifm),
        .conv_out_valid(conv_out_valid), .conv_ofm(conv_ofm),
        .rsp_valid(rsp_valid), .rsp_ofm(rsp_ofm),
        .busy(busy), .tag_err(tag_err), .done_cnt(done_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [12:0] nib_sum(input logic [127:0] v);
        logic [12:0] s;
        s = '0;
        for (int n = 0; n < 32; n++) s = s + 13'(v[4*n +: 4]);
        return s;
    endfunction

    // Datapath stub: pure LAT-cycle delay, never reset, plus an injection hook
    logic [LAT-1:0] sv_d;
    logic [12:0]    so_d [LAT];
    always @(posedge clk) begin
        sv_d[0] <= conv_in_valid;
        so_d[0] <= nib_sum(conv_ifm);
        for (int i = 1; i < LAT; i++) begin
            sv_d[i] <= sv_d[i-1];
            so_d[i] <= so_d[i-1];
        end
    end
    assign conv_out_valid = sv_d[LAT-1] | inj;
    assign conv_ofm       = so_d[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b1; req_valid = '0; inj = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; req_valid = '0; req_ifm = '0; inj = 1'b0;
        for (int i = 0; i < LAT + 3; i++) tick();
        n_checks++;
        if (conv_in_valid !== 1'b0) $display("FAIL reset_in_valid got %b want 0", conv_in_valid); else n_pass++;
        n_checks++;
        if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); else n_pass++;
        n_checks++;
        if (done_cnt !== 16'd0 || tag_err !== 1'b0 || rsp_ofm !== 13'd0 || conv_ifm !== 128'd0)
            $display("FAIL reset_state got cnt=%0d err=%b ofm=%0d ifm=%h want all 0", done_cnt, tag_err, rsp_ofm, conv_ifm);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int lat;
        logic [1:0]  rv;
        logic [12:0] ro;
        lat = 0; rv = '0; ro = '0;
        req_ifm = {128'd0, {32{4'h1}}};
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) $display("FAIL single_ready got %b want 01", req_ready); else n_pass++;
        tick();
        req_valid = 2'b00;
        n_checks++;
        if (conv_in_valid !== 1'b1 || conv_ifm !== {32{4'h1}})
            $display("FAIL single_conv_in got v=%b ifm=%h want v=1 all-1", conv_in_valid, conv_ifm);
        else n_pass++;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (lat == 0 && rsp_valid !== 2'b00) begin
                lat = c; rv = rsp_valid; ro = rsp_ofm;
            end
        end
        n_checks++;
        if (lat != LAT + 1) $display("FAIL single_latency got %0d want %0d", lat, LAT + 1); else n_pass++;
        n_checks++;
        if (rv !== 2'b01 || ro !== 13'd32) $display("FAIL single_rsp got %b/%0d want 01/32", rv, ro); else n_pass++;
        n_checks++;
        if (done_cnt !== 16'd1) $display("FAIL single_done_cnt got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_r;
        logic [12:0] exp_o;
        do_reset();
        req_ifm = {{32{4'h3}}, {32{4'h2}}};
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if (req_ready !== exp_r) $display("FAIL b2b_grant%0d got %b want %b", i, req_ready, exp_r); else n_pass++;
            tick();
        end
        req_valid = 2'b00;
        for (int i = 0; i < 6; i++) begin
            exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_o = (i % 2 == 0) ? 13'd64 : 13'd96;
            n_checks++;
            if (rsp_valid !== exp_r || rsp_ofm !== exp_o)
                $display("FAIL b2b_rsp%0d got %b/%0d want %b/%0d", i, rsp_valid, rsp_ofm, exp_r, exp_o);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (rsp_valid !== 2'b00 || done_cnt !== 16'd6)
            $display("FAIL b2b_end got rsp=%b cnt=%0d want 00/6", rsp_valid, done_cnt);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        int nrsp, last, fall;
        nrsp = 0; last = 0; fall = 0;
        do_reset();
        req_ifm = {{32{4'h3}}, {32{4'h2}}};
        req_valid = 2'b11;
        tick(); tick();
        enable = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 2'b00) $display("FAIL endrop_ready got %b want 00", req_ready); else n_pass++;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (rsp_valid !== 2'b00) begin nrsp++; last = c; end
            if (fall == 0 && nrsp > 0 && busy === 1'b0) fall = c;
        end
        n_checks++;
        if (nrsp != 2) $display("FAIL endrop_rsp_count got %0d want 2", nrsp); else n_pass++;
        n_checks++;
        if (fall != last + 1) $display("FAIL endrop_busy_fall got cycle %0d want %0d", fall, last + 1); else n_pass++;
        enable = 1'b1;
        req_valid = 2'b00;
    endtask

    task automatic test_tag_err();
        do_reset();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        n_checks++;
        if (tag_err !== 1'b1 || rsp_valid !== 2'b00)
            $display("FAIL tagerr_set got err=%b rsp=%b want 1/00", tag_err, rsp_valid);
        else n_pass++;
        tick(); tick(); tick();
        n_checks++;
        if (tag_err !== 1'b1 || done_cnt !== 16'd0)
            $display("FAIL tagerr_sticky got err=%b cnt=%0d want 1/0", tag_err, done_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_in_flight();
        int nrsp;
        nrsp = 0;
        do_reset();
        req_ifm = {128'd0, {32{4'h1}}};
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if (done_cnt !== 16'd1) $display("FAIL rif_pre_cnt got %0d want 1", done_cnt); else n_pass++;
        req_valid = 2'b01;
        tick(); tick(); tick();
        req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (done_cnt !== 16'd0 || tag_err !== 1'b0 || conv_in_valid !== 1'b0)
            $display("FAIL rif_after_reset got cnt=%0d err=%b inv=%b want 0/0/0", done_cnt, tag_err, conv_in_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (tag_err !== 1'b0) $display("FAIL rif_err_early got %b want 0", tag_err); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid !== 2'b00) nrsp++;
        end
        n_checks++;
        if (nrsp != 0) $display("FAIL rif_rsp got %0d responses want 0", nrsp); else n_pass++;
        n_checks++;
        if (tag_err !== 1'b1 || done_cnt !== 16'd0)
            $display("FAIL rif_late_err got err=%b cnt=%0d want 1/0", tag_err, done_cnt);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        req_ifm = {128'd0, {32{4'h1}}};
        req_valid = 2'b01;
        for (int i = 0; i < 65535; i++) tick();
        req_valid = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (done_cnt !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", done_cnt); else n_pass++;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (done_cnt !== 16'h0000 || tag_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL wrap_rollover got cnt=%h err=%b busy=%b want 0000/0/0", done_cnt, tag_err, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_tag_err();
        test_reset_in_flight();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
